// File: rtl/ram_ctrl_pkg.sv
// Shared types and widths for the ram_ctrl backing-store controller.
// States, operation encoding, bus widths and a saturating-increment helper.
package ram_ctrl_pkg;

   localparam int ADDR_W = 24;
   localparam int DATA_W = 32;
   localparam int CNT_W  = 4;
   localparam int STAT_W = 16;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ACCESS,
      ST_DONE,
      ST_HOLD,
      ST_FDRV
   } state_e;

   typedef enum logic {
      OP_RD,
      OP_WR
   } op_e;

   function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/ram_ctrl_mem.sv
// Single-port synchronous main-memory array with registered read; contents
// are deliberately not reset.
module ram_ctrl_mem
   import ram_ctrl_pkg::*;
#(
   parameter int AW = 10
) (
   input  logic              clk,
   input  logic              we,
   input  logic [AW-1:0]     idx,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem_q [0:(1<<AW)-1];

   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[idx] <= wdata;
      end
      rdata <= mem_q[idx];
   end

endmodule

// File: rtl/ram_ctrl.sv
// ram_ctrl: RAM-side controller behind the cache; serves rd/wrt/fetch with a one-cycle cmplt.
// Optional saturating request counters are built when RAM_CTRL_STATS_EN is defined.
module ram_ctrl
   import ram_ctrl_pkg::*;
#(
   parameter int AW      = 10,
   parameter int LATENCY = 3
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] addr_ram,
   inout  wire  [DATA_W-1:0] data_ram,
   input  logic              rd_ram,
   input  logic              wrt_ram,
   input  logic              wrt_bck,
   input  logic              fetch,
   output logic              cmplt,
   output logic              busy
`ifdef RAM_CTRL_STATS_EN
   ,
   output logic [STAT_W-1:0] rd_cnt,
   output logic [STAT_W-1:0] wr_cnt,
   output logic [STAT_W-1:0] wb_cnt
`endif
);

   localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(LATENCY - 1);

   state_e            state_q, state_d;
   op_e               op_q, op_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [AW-1:0]     idx_q, idx_d;
   logic [AW-1:0]     req_idx, mem_idx;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic [DATA_W-1:0] mem_rdata;
   logic              cmplt_q, cmplt_d;
   logic              busy_q, busy_d;
   logic              mem_we, drive_en;

   assign req_idx = addr_ram[AW+1:2];
   // Present the incoming index while idle so the registered read is ready even for LATENCY=1.
   assign mem_idx = (state_q == ST_IDLE) ? req_idx : idx_q;
   assign mem_we  = reset && (state_q == ST_ACCESS) && (cnt_q == '0) && (op_q == OP_WR);

   ram_ctrl_mem #(.AW(AW)) u_mem (
      .clk   (clk),
      .we    (mem_we),
      .idx   (mem_idx),
      .wdata (wdata_q),
      .rdata (mem_rdata)
   );

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      cmplt_d = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (wrt_ram) begin
               idx_d   = req_idx;
               wdata_d = data_ram;
               op_d    = OP_WR;
               cnt_d   = LAT_M1;
               state_d = ST_ACCESS;
            end else if (rd_ram) begin
               idx_d   = req_idx;
               op_d    = OP_RD;
               cnt_d   = LAT_M1;
               state_d = ST_ACCESS;
            end else if (fetch) begin
               cmplt_d = 1'b1;
               state_d = ST_FDRV;
            end
         end
         ST_ACCESS: begin
            if (cnt_q == '0) begin
               if (op_q == OP_RD) begin
                  rdata_d = mem_rdata;
               end
               cmplt_d = 1'b1;
               state_d = ST_DONE;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         ST_DONE: state_d = ST_HOLD;
         ST_HOLD: begin
            // Only the originating level releases HOLD, so a late drop cannot retrigger.
            if ((op_q == OP_WR && !wrt_ram) || (op_q == OP_RD && !rd_ram)) begin
               state_d = ST_IDLE;
            end
         end
         ST_FDRV: begin
            if (!fetch) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         op_q    <= OP_RD;
         cnt_q   <= '0;
         rdata_q <= '0;
         cmplt_q <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         cnt_q   <= cnt_d;
         rdata_q <= rdata_d;
         cmplt_q <= cmplt_d;
         busy_q  <= busy_d;
      end
   end

   always_ff @(posedge clk) begin
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
   end

   assign drive_en = reset && fetch && (state_q == ST_FDRV);
   assign data_ram = drive_en ? rdata_q : {DATA_W{1'bz}};
   assign cmplt    = cmplt_q;
   assign busy     = busy_q;

`ifdef RAM_CTRL_STATS_EN
   logic              wb_q, wb_d;
   logic [STAT_W-1:0] rd_cnt_q, rd_cnt_d;
   logic [STAT_W-1:0] wr_cnt_q, wr_cnt_d;
   logic [STAT_W-1:0] wb_cnt_q, wb_cnt_d;

   always_comb begin
      wb_d     = wb_q;
      rd_cnt_d = rd_cnt_q;
      wr_cnt_d = wr_cnt_q;
      wb_cnt_d = wb_cnt_q;
      if (state_q == ST_IDLE && wrt_ram) begin
         wb_d = wrt_bck;
      end
      if (state_q == ST_DONE) begin
         if (op_q == OP_RD) begin
            rd_cnt_d = sat_inc(rd_cnt_q);
         end else begin
            wr_cnt_d = sat_inc(wr_cnt_q);
            if (wb_q) begin
               wb_cnt_d = sat_inc(wb_cnt_q);
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      wb_q <= wb_d;
      if (!reset) begin
         rd_cnt_q <= '0;
         wr_cnt_q <= '0;
         wb_cnt_q <= '0;
      end else begin
         rd_cnt_q <= rd_cnt_d;
         wr_cnt_q <= wr_cnt_d;
         wb_cnt_q <= wb_cnt_d;
      end
   end

   assign rd_cnt = rd_cnt_q;
   assign wr_cnt = wr_cnt_q;
   assign wb_cnt = wb_cnt_q;
`else
   logic unused_wb;
   assign unused_wb = wrt_bck;
`endif

   // Byte-offset and above-array address bits alias by design.
   logic unused_addr;
   assign unused_addr = ^{addr_ram[ADDR_W-1:AW+2], addr_ram[1:0]};

endmodule

// File: tb/tb_ram_ctrl.sv
// Self-checking bench for ram_ctrl: vector table, corner-case sequences and
// randomized traffic against a word-array reference model.
module tb_ram_ctrl;

   localparam int AW  = 10;
   localparam int LAT = 3;
   localparam int OP_W = 0;
   localparam int OP_R = 1;
   localparam int OP_F = 2;

   typedef struct {
      int          op;
      logic [23:0] addr;
      logic [31:0] data;
      logic        wb;
      logic [31:0] exp;
   } vec_t;

   logic        clk = 1'b0;
   logic        reset;
   logic [23:0] addr_ram;
   logic        rd_ram, wrt_ram, wrt_bck, fetch;
   logic        cmplt, busy;
   logic        tb_oe;
   logic [31:0] tb_wdata;
   wire  [31:0] data_bus;

   assign data_bus = tb_oe ? tb_wdata : 32'bz;

`ifdef RAM_CTRL_STATS_EN
   logic [15:0] rd_cnt, wr_cnt, wb_cnt;
`endif

   ram_ctrl #(.AW(AW), .LATENCY(LAT)) dut (
      .clk      (clk),
      .reset    (reset),
      .addr_ram (addr_ram),
      .data_ram (data_bus),
      .rd_ram   (rd_ram),
      .wrt_ram  (wrt_ram),
      .wrt_bck  (wrt_bck),
      .fetch    (fetch),
      .cmplt    (cmplt),
      .busy     (busy)
`ifdef RAM_CTRL_STATS_EN
      ,
      .rd_cnt   (rd_cnt),
      .wr_cnt   (wr_cnt),
      .wb_cnt   (wb_cnt)
`endif
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: word array keyed by word index plus last-read register.
   logic [31:0] mdl_mem [int];
   logic [31:0] mdl_rdata;

   function automatic int widx(input logic [23:0] a);
      return int'(a >> 2) % (1 << AW);
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic check_released(input string name);
      logic [31:0] zval;
      zval = 32'bz;
      n_tests++;
      if (!((data_bus === zval) || (data_bus === 32'h0))) begin
         n_fail++;
         $display("FAIL %s: bus %h still driven, expected released", name, data_bus);
      end
   endtask

   task automatic wait_cmplt(output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!cmplt && n < 60);
   endtask

   task automatic do_req(input bit is_wr, input logic [23:0] a, input logic [31:0] d, input bit wb);
      int n;
      @(negedge clk);
      addr_ram = a; tb_wdata = d; tb_oe = is_wr;
      wrt_ram = is_wr; rd_ram = !is_wr; wrt_bck = wb;
      wait_cmplt(n);
      check(is_wr ? "wr_latency" : "rd_latency", 32'(n), 32'(LAT + 1));
      @(negedge clk);
      check("cmplt_width", 32'(cmplt), 32'd0);
      check("busy_hold", 32'(busy), 32'd1);
      rd_ram = 1'b0; wrt_ram = 1'b0; wrt_bck = 1'b0; tb_oe = 1'b0;
      @(negedge clk);
      check("idle_after_drop", 32'(busy), 32'd0);
      if (is_wr) mdl_mem[widx(a)] = d;
      else mdl_rdata = mdl_mem.exists(widx(a)) ? mdl_mem[widx(a)] : 32'h0;
   endtask

   task automatic do_fetch(input logic [31:0] exp);
      @(negedge clk);
      fetch = 1'b1;
      @(negedge clk);
      check("fetch_cmplt", 32'(cmplt), 32'd1);
      check("fetch_data", data_bus, exp);
      @(negedge clk);
      check("fetch_cmplt_once", 32'(cmplt), 32'd0);
      check("fetch_data_held", data_bus, exp);
      fetch = 1'b0;
      #1;
      check_released("fetch_release");
      @(negedge clk);
      check("fetch_idle", 32'(busy), 32'd0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      mdl_rdata = 32'h0;
   endtask

   vec_t tbl [14];

   initial begin
      int n;
      logic [23:0] a;
      logic [31:0] d;
      reset = 1'b0; addr_ram = '0; rd_ram = 1'b0; wrt_ram = 1'b0;
      wrt_bck = 1'b0; fetch = 1'b0; tb_oe = 1'b0; tb_wdata = '0;
      mdl_rdata = 32'h0;

      tbl = '{
         '{OP_F, 24'h000000, 32'h0,         1'b0, 32'h00000000},
         '{OP_W, 24'h000000, 32'h00000000,  1'b0, 32'h0},
         '{OP_R, 24'h000000, 32'h0,         1'b0, 32'h0},
         '{OP_F, 24'h000000, 32'h0,         1'b0, 32'h00000000},
         '{OP_W, 24'h000004, 32'h66666666,  1'b1, 32'h0},
         '{OP_R, 24'h000004, 32'h0,         1'b0, 32'h0},
         '{OP_F, 24'h000000, 32'h0,         1'b0, 32'h66666666},
         '{OP_W, 24'hFFF008, 32'hDEADBEEF,  1'b0, 32'h0},
         '{OP_R, 24'h00000B, 32'h0,         1'b0, 32'h0},
         '{OP_F, 24'h000000, 32'h0,         1'b0, 32'hDEADBEEF},
         '{OP_W, 24'h000010, 32'hA5A50F0F,  1'b1, 32'h0},
         '{OP_R, 24'h000004, 32'h0,         1'b0, 32'h0},
         '{OP_F, 24'h000000, 32'h0,         1'b0, 32'h66666666},
         '{OP_F, 24'h000000, 32'h0,         1'b0, 32'h66666666}
      };

      repeat (3) @(negedge clk);
      check("rst_cmplt", 32'(cmplt), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check_released("rst_bus");
      reset = 1'b1;

      foreach (tbl[i]) begin
         case (tbl[i].op)
            OP_W: do_req(1'b1, tbl[i].addr, tbl[i].data, tbl[i].wb);
            OP_R: do_req(1'b0, tbl[i].addr, 32'h0, 1'b0);
            default: do_fetch(tbl[i].exp);
         endcase
      end

      // Simultaneous read and write: write first, read follows once HOLD releases.
      @(negedge clk);
      addr_ram = 24'h000008; tb_wdata = 32'h55BCBCBC; tb_oe = 1'b1;
      wrt_ram = 1'b1; rd_ram = 1'b1;
      wait_cmplt(n);
      check("both_wr_latency", 32'(n), 32'(LAT + 1));
      @(negedge clk);
      wrt_ram = 1'b0; tb_oe = 1'b0;
      wait_cmplt(n);
      check("both_rd_latency", 32'(n), 32'(LAT + 2));
      @(negedge clk);
      rd_ram = 1'b0;
      @(negedge clk);
      mdl_mem[2] = 32'h55BCBCBC;
      mdl_rdata  = 32'h55BCBCBC;
      do_fetch(32'h55BCBCBC);

      // Request held past cmplt must not retrigger.
      @(negedge clk);
      addr_ram = 24'h000004; rd_ram = 1'b1;
      wait_cmplt(n);
      check("held_latency", 32'(n), 32'(LAT + 1));
      repeat (3) begin
         @(negedge clk);
         check("held_no_cmplt", 32'(cmplt), 32'd0);
         check("held_busy", 32'(busy), 32'd1);
      end
      rd_ram = 1'b0;
      @(negedge clk);
      check("held_idle", 32'(busy), 32'd0);
      @(negedge clk);
      check("held_no_late_cmplt", 32'(cmplt), 32'd0);
      mdl_rdata = mdl_mem[1];

      // Reset during the last ACCESS cycle of a write aborts it.
      do_req(1'b1, 24'h00000C, 32'hAAAA0000, 1'b0);
      @(negedge clk);
      addr_ram = 24'h00000C; tb_wdata = 32'h12345678; tb_oe = 1'b1; wrt_ram = 1'b1;
      repeat (LAT) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("abort_cmplt", 32'(cmplt), 32'd0);
      check("abort_busy", 32'(busy), 32'd0);
      wrt_ram = 1'b0; tb_oe = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      mdl_rdata = 32'h0;
      check("abort_no_cmplt_after", 32'(cmplt), 32'd0);
      do_fetch(32'h0);
      do_req(1'b0, 24'h00000C, 32'h0, 1'b0);
      do_fetch(32'hAAAA0000);

      // Reset while driving the bus releases it.
      @(negedge clk);
      fetch = 1'b1;
      @(negedge clk);
      check("fdrv_rst_before", data_bus, 32'hAAAA0000);
      reset = 1'b0;
      @(negedge clk);
      check_released("fdrv_rst_release");
      check("fdrv_rst_busy", 32'(busy), 32'd0);
      fetch = 1'b0;
      reset = 1'b1;
      mdl_rdata = 32'h0;
      @(negedge clk);

      // Randomized traffic against the model over a small aliased index window.
      for (int i = 0; i < 16; i++) begin
         a = 24'($urandom);
         a[11:2] = 10'(i);
         do_req(1'b1, a, $urandom, 1'($urandom_range(0, 1)));
      end
      for (int k = 0; k < 40; k++) begin
         a = 24'($urandom);
         a[11:2] = 10'($urandom_range(0, 15));
         d = $urandom;
         case ($urandom_range(0, 2))
            0: do_req(1'b1, a, d, 1'($urandom_range(0, 1)));
            1: do_req(1'b0, a, 32'h0, 1'b0);
            default: do_fetch(mdl_rdata);
         endcase
      end

`ifdef RAM_CTRL_STATS_EN
      do_reset();
      check("stats_rst_rd", 32'(rd_cnt), 32'd0);
      do_req(1'b1, 24'h000000, 32'h11111111, 1'b0);
      do_req(1'b1, 24'h000004, 32'h22222222, 1'b1);
      do_req(1'b0, 24'h000000, 32'h0, 1'b0);
      do_req(1'b1, 24'h000008, 32'h33333333, 1'b0);
      do_req(1'b0, 24'h000004, 32'h0, 1'b0);
      check("stats_rd_cnt", 32'(rd_cnt), 32'd2);
      check("stats_wr_cnt", 32'(wr_cnt), 32'd3);
      check("stats_wb_cnt", 32'(wb_cnt), 32'd1);
`endif

      repeat (2) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/ram_ctrl.md
# ram_ctrl

Word-addressed backing-store controller that sits directly downstream of the cache, on its RAM side. Serves the cache's `rd_ram`/`wrt_ram`/`fetch` requests over the shared 32-bit `data_ram` bus. Answers each request with a single-cycle `cmplt` pulse after a programmable access latency. Holds the main-memory array, so cache miss, write-back and line-replace sequences run against real storage in simulation and synthesis.

## Interface
- `AW`, 10: word-index width; array depth is 2^AW 32-bit words.
- `LATENCY`, 3: cycles from request acceptance to `cmplt` for read/write; legal range 1..15.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-low reset.
- `addr_ram`  in  24  byte address from cache; word index = `addr_ram[AW+1:2]`; upper bits ignored (aliasing).
- `data_ram`  inout  32  shared bus; cache drives on writes, ram_ctrl drives only while `fetch`=1.
- `rd_ram`  in  1  read request, level, held until `cmplt`.
- `wrt_ram`  in  1  write request, level, held until `cmplt`.
- `wrt_bck`  in  1  qualifies a write as a dirty-line write-back (statistics only).
- `fetch`  in  1  cache requests delivery of the last read word on `data_ram`.
- `cmplt`  out  1  one-cycle completion pulse.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- States: IDLE, ACCESS, DONE, HOLD, FDRV.
- IDLE, priority: `wrt_ram` > `rd_ram` > `fetch`.
  - On `wrt_ram`: latch word index and `data_ram`; load counter = LATENCY-1; go to ACCESS (op=WR).
  - On `rd_ram`: latch index; go to ACCESS (op=RD).
  - On `fetch`: go to FDRV.
- ACCESS: counter decrements each cycle. At 0:
  - WR writes the array.
  - RD loads `rdata` from the array.
  - Go to DONE.
- DONE: `cmplt`=1 for exactly this cycle; go to HOLD.
- HOLD: wait until the originating request (`rd_ram` or `wrt_ram`) is low, then go to IDLE. This prevents a late-dropped level from retriggering the access.
- FDRV:
  - Drive `data_ram`=`rdata` (tri-state otherwise).
  - `cmplt`=1 in the cycle after entry.
  - Then HOLD on `fetch`, continuing to drive while `fetch`=1.
- `rdata` persists until the next RD completes; fetch without a prior read returns 0 (reset value).
- Simultaneous `rd_ram`+`wrt_ram`: write served first; read accepted from IDLE once the write's HOLD releases, if still asserted.
- `wrt_bck` is sampled with `wrt_ram` at acceptance.

## Timing
- Request sampled high in IDLE at edge N gives `cmplt` high in cycle N+LATENCY+1, low at N+LATENCY+2.
- Minimum back-to-back request spacing is LATENCY+3 cycles (including the HOLD release cycle).
- Fetch: `fetch` sampled at edge N gives `cmplt` in cycle N+1. `data_ram` is valid from cycle N+1 until `fetch` falls.
- Reset values: `cmplt`=0, `busy`=0, `data_ram`=Z, `rdata`=0, state IDLE, counter 0.
- Array contents are not cleared by reset.
- Reset mid-ACCESS aborts the access: no array write, no `cmplt`.
- Reset mid-FDRV releases the bus in the same cycle reset is sampled.

## Configuration
- `RAM_CTRL_STATS_EN` defined:
  - Three 16-bit saturating counters, `rd_cnt`, `wr_cnt` and `wb_cnt`, increment in DONE. `wb_cnt` counts writes with `wrt_bck`=1.
  - Exposed as output ports; cleared by reset.
- Undefined: counters and ports absent; behaviour otherwise identical.

## Structure
- `ram_ctrl_pkg`: state enum, op enum (RD/WR), `ADDR_W`=24, `DATA_W`=32, counter width constant.
- Sub-module `ram_ctrl_mem`: single-port synchronous array (`we`, `idx`, `wdata`, `rdata`), no reset; ram_ctrl instantiates one.

## Test plan
- Reset then `rd_ram` at 0x000000 with LATENCY=3 -> `cmplt` exactly 4 cycles after acceptance, one cycle wide; fetch returns 0x00000000.
- `wrt_ram`+`wrt_bck` at 0x000004, data 0x66666666; then `rd_ram` 0x000004; then `fetch` -> `data_ram`=0x66666666 in the cycle after `fetch`, Z after `fetch` drops.
- `rd_ram` and `wrt_ram` both high, addr 0x000008, data 0x55BCBCBC -> write completes first; second `cmplt` delivers 0x55BCBCBC.
- Request held 3 cycles past `cmplt` -> no second `cmplt`; IDLE only after drop.
- Reset asserted in ACCESS of a write of 0x12345678 to 0x00000C -> no `cmplt`; later read returns prior contents.
- With `RAM_CTRL_STATS_EN`: 2 reads, 3 writes (1 write-back) -> `rd_cnt`=2, `wr_cnt`=3, `wb_cnt`=1.
